// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the register_file write port, with a busy scoreboard for decode hazard checks.
// Optional macro RF_WB_BYPASS_EN: early scoreboard clear at the handshake plus write-stage forwarding ports.
module rf_wb_arbiter #(
    parameter int                    WIDTH         = 32,
    parameter int                    ADDR_SPACE    = 5,
    parameter int                    REG_AMOUNT    = 32,
    parameter int                    NUM_REQ       = 3,
    parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_SPACE-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        wr_en,
    output logic [ADDR_SPACE-1:0]       wr_addr,
    output logic [WIDTH-1:0]            wr_data,
    input  logic                        issue_valid,
    input  logic [ADDR_SPACE-1:0]       issue_addr,
    input  logic [ADDR_SPACE-1:0]       chk1_addr,
    input  logic [ADDR_SPACE-1:0]       chk2_addr,
`ifdef RF_WB_BYPASS_EN
    output logic                        fwd1_hit,
    output logic                        fwd2_hit,
    output logic [WIDTH-1:0]            fwd1_data,
    output logic [WIDTH-1:0]            fwd2_data,
`endif
    output logic                        chk1_busy,
    output logic                        chk2_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      winner;
    logic                  found;
    logic [NUM_REQ-1:0]    grant;
    logic                  xfer;
    logic [ADDR_SPACE-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_data;
    logic                  sel_nonzero;
    logic [REG_AMOUNT-1:0] busy;
    logic [REG_AMOUNT-1:0] busy_nxt;
    logic                  clr_en;
    logic [ADDR_SPACE-1:0] clr_addr;

    // Arbitration: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found)
            grant[winner] = 1'b1;
    end

    // No grant is visible while reset is held
    assign req_ready   = rst ? grant : '0;
    assign xfer        = rst & found;
    assign sel_addr    = req_addr[winner*ADDR_SPACE +: ADDR_SPACE];
    assign sel_data    = req_data[winner*WIDTH +: WIDTH];
    assign sel_nonzero = (sel_addr != ZERO_REGISTER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (xfer)
            rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end

    // Write stage: one cycle after the handshake, register_file commits on the next edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (xfer) begin
            wr_en   <= sel_nonzero;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Scoreboard: clear first so a same-edge issue of the same register wins
    always_comb begin
`ifdef RF_WB_BYPASS_EN
        clr_en   = xfer & sel_nonzero;
        clr_addr = sel_addr;
`else
        clr_en   = wr_en;
        clr_addr = wr_addr;
`endif
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_addr] = 1'b0;
        if (issue_valid && issue_addr != ZERO_REGISTER)
            busy_nxt[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign chk1_busy = busy[chk1_addr] & (chk1_addr != ZERO_REGISTER);
    assign chk2_busy = busy[chk2_addr] & (chk2_addr != ZERO_REGISTER);

`ifdef RF_WB_BYPASS_EN
    assign fwd1_hit  = wr_en & (wr_addr == chk1_addr) & (chk1_addr != ZERO_REGISTER);
    assign fwd2_hit  = wr_en & (wr_addr == chk2_addr) & (chk2_addr != ZERO_REGISTER);
    assign fwd1_data = wr_data;
    assign fwd2_data = wr_data;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a small register_file model on the write port.
module tb_rf_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int NREQ  = 3;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              issue_valid;
    logic [AW-1:0]     issue_addr;
    logic [AW-1:0]     chk1_addr;
    logic [AW-1:0]     chk2_addr;
    logic              chk1_busy;
    logic              chk2_busy;
`ifdef RF_WB_BYPASS_EN
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [WIDTH-1:0]  fwd1_data;
    logic [WIDTH-1:0]  fwd2_data;
`endif

    logic [WIDTH-1:0]  rf_mem [32];
    int                n_checks;
    int                n_errors;
    int                exp_grant [6];
    int                exp_addr  [6];

    rf_wb_arbiter #(
        .WIDTH(WIDTH), .ADDR_SPACE(AW), .REG_AMOUNT(32), .NUM_REQ(NREQ), .ZERO_REGISTER(5'b00000)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .chk1_addr(chk1_addr), .chk2_addr(chk2_addr),
`ifdef RF_WB_BYPASS_EN
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
        .chk1_busy(chk1_busy), .chk2_busy(chk2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register_file stand-in: commits whatever the write stage presents
    always @(posedge clk) begin
        if (wr_en)
            rf_mem[wr_addr] <= wr_data;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_addr[i*AW +: AW]       = a;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        int  waited;
        bit  got;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        exp_grant = '{1, 2, 4, 1, 2, 4};
        exp_addr  = '{1, 2, 3, 1, 2, 3};
        rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        issue_valid = 1'b0; issue_addr = '0; chk1_addr = '0; chk2_addr = '0;

        // reset state, including no grant while held
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 3'b111;
        #1;
        check_val("rst_ready", 32'(req_ready), 0);
        check_val("rst_wr_en", 32'(wr_en), 0);
        check_val("rst_wr_addr", 32'(wr_addr), 0);
        check_val("rst_wr_data", wr_data, 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;

        // single write
        @(negedge clk);
        set_req(0, 5, 59);
        req_valid = 3'b001;
        #1;
        check_val("single_ready", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        check_val("single_wr_en", 32'(wr_en), 1);
        check_val("single_wr_addr", 32'(wr_addr), 5);
        check_val("single_wr_data", wr_data, 59);
        tick();
        check_val("single_idle_wr_en", 32'(wr_en), 0);
        check_val("single_hold_addr", 32'(wr_addr), 5);
        check_val("single_rf", rf_mem[5], 59);

        // zero register through requester 2 (pointer at 1 -> wraps to 2)
        @(negedge clk);
        set_req(2, 0, 32'hDEADBEEF);
        req_valid = 3'b100;
        issue_valid = 1'b1; issue_addr = 0; chk1_addr = 0;
        #1;
        check_val("zero_ready", 32'(req_ready), 4);
        tick();
        req_valid = '0; issue_valid = 1'b0;
        check_val("zero_wr_en", 32'(wr_en), 0);
        check_val("zero_chk_busy", 32'(chk1_busy), 0);
        tick();
        check_val("zero_rf", rf_mem[0], 0);

        // round robin, pointer now 0
        @(negedge clk);
        set_req(0, 1, 32'h100); set_req(1, 2, 32'h101); set_req(2, 3, 32'h102);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_val("rr_ready", 32'(req_ready), 32'(exp_grant[k]));
            tick();
            check_val("rr_wr_en", 32'(wr_en), 1);
            check_val("rr_wr_addr", 32'(wr_addr), 32'(exp_addr[k]));
            check_val("rr_wr_data", wr_data, 32'h100 + 32'(exp_addr[k]) - 1);
            @(negedge clk);
        end
        req_valid = '0;

        // scoreboard set / clear timing, pointer now 0
        issue_valid = 1'b1; issue_addr = 9; chk1_addr = 9; chk2_addr = 9;
        #1;
        check_val("sb_before_set", 32'(chk1_busy), 0);
        tick();
        issue_valid = 1'b0;
        check_val("sb_set1", 32'(chk1_busy), 1);
        check_val("sb_set2", 32'(chk2_busy), 1);
        @(negedge clk);
        set_req(0, 9, 32'h99);
        req_valid = 3'b001;
        #1;
        check_val("sb_wb_ready", 32'(req_ready), 1);
        tick();
        req_valid = '0;
`ifdef RF_WB_BYPASS_EN
        check_val("sb_after_hs", 32'(chk1_busy), 0);
        check_val("fwd1_hit", 32'(fwd1_hit), 1);
        check_val("fwd1_data", fwd1_data, 32'h99);
`else
        check_val("sb_after_hs", 32'(chk1_busy), 1);
`endif
        tick();
        check_val("sb_cleared", 32'(chk1_busy), 0);
        check_val("sb_rf", rf_mem[9], 32'h99);

        // same-edge set and clear of register 9, pointer now 1
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 9;
        tick();
        issue_valid = 1'b0;
        check_val("se_set", 32'(chk1_busy), 1);
        @(negedge clk);
        set_req(1, 9, 32'h77);
        req_valid = 3'b010;
`ifdef RF_WB_BYPASS_EN
        issue_valid = 1'b1;
`endif
        #1;
        check_val("se_ready", 32'(req_ready), 2);
        tick();
        req_valid = '0; issue_valid = 1'b0;
`ifndef RF_WB_BYPASS_EN
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 9;
        tick();
        issue_valid = 1'b0;
`endif
        check_val("se_set_wins", 32'(chk1_busy), 1);
        tick();
        check_val("se_still_busy", 32'(chk1_busy), 1);

        // stalled requester 1 while requester 0 streams, pointer now 2
        @(negedge clk);
        set_req(0, 10, 32'h10); set_req(1, 4, 32'h44);
        req_valid = 3'b011;
        waited = 0; got = 1'b0;
        while (!got && waited < NREQ) begin
            #1;
            if (req_ready == 3'b010) got = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check_val("stall_granted", 32'(got), 1);
        check_val("stall_wait", 32'(waited), 1);
        tick();
        req_valid = 3'b001;
        check_val("stall_wr_en", 32'(wr_en), 1);
        check_val("stall_wr_addr", 32'(wr_addr), 4);
        check_val("stall_wr_data", wr_data, 32'h44);
        @(negedge clk);
        req_valid = '0;

        // reset mid-operation with a pending write and a busy register
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 7; chk1_addr = 7;
        set_req(2, 12, 32'h12);
        req_valid = 3'b100;
        tick();
        req_valid = '0; issue_valid = 1'b0;
        check_val("mid_wr_en", 32'(wr_en), 1);
        check_val("mid_busy", 32'(chk1_busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_rst_wr_en", 32'(wr_en), 0);
        check_val("mid_rst_wr_addr", 32'(wr_addr), 0);
        check_val("mid_rst_wr_data", wr_data, 0);
        check_val("mid_rst_busy", 32'(chk1_busy), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_val("mid_no_commit", rf_mem[12], 0);
        check_val("mid_post_busy", 32'(chk1_busy), 0);
        check_val("mid_post_wr_en", 32'(wr_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences the single write port of register_file between NUM_REQ writeback sources (ALU, LSU, MUL …) using round-robin arbitration.
- Maintains a busy scoreboard of destination registers: set when an instruction issues, cleared when its writeback lands.
- Sits between the execute units and register_file. Drives wr_en/wr_addr/wr_data directly and answers hazard queries from decode.

Parameters:
- WIDTH, 32 (`WORD), data width.
- ADDR_SPACE, 5, register address width.
- REG_AMOUNT, 32, number of architectural registers.
- NUM_REQ, 3, number of writeback requesters (2..8).
- ZERO_REGISTER, 5'b00000, hardwired-zero register address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester writeback valid.
- req_addr  in  NUM_REQ*ADDR_SPACE  packed destination addresses, requester i at [i*ADDR_SPACE +: ADDR_SPACE].
- req_data  in  NUM_REQ*WIDTH  packed writeback data.
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when valid&ready.
- wr_en  out  1  to register_file.
- wr_addr  out  ADDR_SPACE  to register_file.
- wr_data  out  WIDTH  to register_file.
- issue_valid  in  1  an instruction with a destination is issuing.
- issue_addr  in  ADDR_SPACE  its destination register.
- chk1_addr  in  ADDR_SPACE  hazard query address, port 1.
- chk2_addr  in  ADDR_SPACE  hazard query address, port 2.
- chk1_busy  out  1  query result, port 1.
- chk2_busy  out  1  query result, port 2.

Behaviour:
- Reset (rst=0, async):
  - wr_en=0, wr_addr=0, wr_data=0.
  - busy[]=0, rr_ptr=0.
  - req_ready=0 while in reset.
- Arbitration is combinational from req_valid and rr_ptr.
  - The winner is the first valid requester starting at index rr_ptr and wrapping modulo NUM_REQ.
  - req_ready is one-hot to the winner, or all zero if nothing is valid.
- rr_ptr update: on a transfer, rr_ptr <= (winner+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Requester rule: req_valid, req_addr and req_data must stay stable until accepted. A deasserted valid may never be granted.
- Write stage is registered, latency 1. At the transfer edge:
  - wr_en <= 1 (or 0 if req_addr==ZERO_REGISTER);
  - wr_addr <= req_addr;
  - wr_data <= req_data.
  Otherwise wr_en <= 0 and wr_addr/wr_data hold. register_file commits on the following edge.
- Writes to ZERO_REGISTER are accepted (ready=1, consumed) but never drive wr_en and never touch the scoreboard.
- Scoreboard:
  - issue_valid & issue_addr!=ZERO_REGISTER sets busy[issue_addr] at the next edge.
  - Clear (no bypass): busy[wr_addr] clears at the edge where wr_en=1, i.e. when register_file commits. Clear happens 2 edges after the handshake.
  - Set and clear of the same address on the same edge: set wins (a newer producer is in flight).
- chk_busy = busy[chk_addr] & (chk_addr!=ZERO_REGISTER). Combinational read of state; no write-through.
- Throughput: one writeback per cycle sustained. With all requesters valid, grants rotate 0,1,2,0…
- Reset mid-operation: a pending write stage is discarded (wr_en=0), the scoreboard is cleared, and no partial commit occurs.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined:
  - busy clears at the handshake edge (1 edge earlier).
  - Adds ports fwd1_hit/fwd2_hit (out, 1) and fwd1_data/fwd2_data (out, WIDTH).
  - fwdN_hit = wr_en & (wr_addr==chkN_addr) & (chkN_addr!=ZERO_REGISTER); fwdN_data = wr_data.
  - This lets decode consume a value still in the write stage.
- Not defined: no fwd ports; clear timing as in Behaviour.

Test Plan:
- Reset: drive rst=0 mid-cycle with wr_en=1 and busy[7]=1 → outputs go to 0 immediately; after release chk1_addr=7 gives chk1_busy=0.
- Single write: req_valid=3'b001, addr=5, data=59 → req_ready=3'b001 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=59; register_file r1 at addr 5 reads 59 one edge later.
- Round-robin: all three valid for 6 cycles with addrs 1/2/3 → grant order 0,1,2,0,1,2; wr_addr sequence 1,2,3,1,2,3; no cycle without wr_en.
- Zero register: req addr=0, data=0xDEADBEEF → req_ready=1, wr_en stays 0, r1 at x0 reads 0; chk1_addr=0 gives chk1_busy=0 even after issue of addr 0.
- Scoreboard: issue addr=9 → chk1_busy=1 next cycle; writeback to 9 → chk1_busy=0 exactly 2 edges after handshake (1 with RF_WB_BYPASS_EN, where fwd1_hit=1 and fwd1_data=value in between). Same-edge issue and clear of 9 → busy stays 1.
- Stalled requester: requester 1 valid with addr=4 while requester 0 streams → requester 1 is granted within NUM_REQ cycles, with its data unchanged at wr_data.
